// File: rtl/block_serializer_if.sv
// Block-to-byte link: a parallel block goes in, a byte stream with last-byte marker comes out.
// The master drives the block source and the byte sink; the slave is the serializer.
interface block_serializer_if #(
    parameter int WIDTH = 352
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_state;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/block_serializer.sv
// Double-buffered block serializer: a hold register catches the next block while the
// shifter streams the current one MSB byte first, so consecutive blocks leave back-to-back.

// One byte lane of the hold/shift storage. Lane NBYTES-1 carries the byte on the wire.
module block_serializer_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_hold,
    input  logic       load_shift,
    input  logic       shift_en,
    input  logic [7:0] in_byte,
    input  logic [7:0] shift_in,
    output logic [7:0] shift_byte
);
    logic [7:0] hold_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_byte  <= '0;
            shift_byte <= '0;
        end else begin
            if (load_hold)
                hold_byte <= in_byte;
            // a new block replaces whatever was left in the shifter
            if (load_shift)
                shift_byte <= hold_byte;
            else if (shift_en)
                shift_byte <= shift_in;
        end
    end
endmodule

module block_serializer #(
    parameter int WIDTH = 352
) (
    input  logic               clk,
    input  logic               rst,
    block_serializer_if.slave  bus
);
    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = $clog2(NBYTES + 1);

    generate
        if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_chk
            $error("block_serializer: WIDTH must be a positive multiple of 8");
        end
    endgenerate

    logic                       hold_full;
    logic [CW-1:0]              cnt;
    logic [NBYTES-1:0][7:0]     in_bytes;
    logic [NBYTES-1:0][7:0]     shift_bytes;
    logic [NBYTES-1:0][7:0]     shift_in;
    logic                       accept;
    logic                       byte_hs;
    logic                       shifter_free;
    logic                       transfer;

    // packed byte index NBYTES-1 is the MSB byte, i.e. the first one sent
    assign in_bytes = bus.in_state;
    assign shift_in = {shift_bytes[NBYTES-2:0], 8'h00};

    assign accept       = bus.in_valid & ~hold_full;
    assign byte_hs      = (cnt != '0) & bus.out_ready;
    assign shifter_free = (cnt == '0) | ((cnt == CW'(1)) & byte_hs);
    assign transfer     = hold_full & shifter_free;

    block_serializer_lane u_lane [NBYTES-1:0] (
        .clk        (clk),
        .rst        (rst),
        .load_hold  (accept),
        .load_shift (transfer),
        .shift_en   (byte_hs),
        .in_byte    (in_bytes),
        .shift_in   (shift_in),
        .shift_byte (shift_bytes)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            // accept needs an empty hold register, so it never coincides with transfer
            if (accept)
                hold_full <= 1'b1;
            if (transfer) begin
                hold_full <= 1'b0;
                cnt       <= CW'(NBYTES);
            end else if (byte_hs) begin
                cnt       <= cnt - CW'(1);
            end
        end
    end

    assign bus.in_ready  = ~hold_full;
    assign bus.out_valid = (cnt != '0);
    assign bus.out_data  = shift_bytes[NBYTES-1];
    assign bus.out_last  = (cnt == CW'(1));
    assign bus.busy      = hold_full | (cnt != '0);
endmodule
